// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with programmable 16x oversampling, receive FIFO
//            and a small register interface. Define UART_RX_MAJORITY_EN for
//            2-of-3 majority sampling at ticks 7/8/9 of each bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wren,
    input  logic       rden,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rxin,
    output logic       rxirq
);

    localparam int               c_AW          = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]    c_DEPTH       = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]    c_CNT_ONE     = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0]  c_PTR_ONE     = c_AW'(1);
    localparam logic [2:0]       c_ADDR_PERIOD = 3'd0;
    localparam logic [2:0]       c_ADDR_RXDATA = 3'd2;
    localparam logic [2:0]       c_ADDR_STATUS = 3'd3;
    localparam logic [7:0]       c_PERIOD_RST  = 8'h0C;
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0]       c_DECIDE_TCNT = 4'd8;
`else
    localparam logic [3:0]       c_DECIDE_TCNT = 4'd7;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_WAITHI = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_sync;
    logic              r_rx_prev;
    logic              w_rx;
    logic              w_sample;
    logic [7:0]        r_period;
    logic [8:0]        r_tick_cnt;
    logic              w_tick;
    logic [3:0]        r_tcnt;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shift;
    logic              w_decide;
    logic              w_restart;
    logic              w_shift;
    logic              w_push_req;
    logic              w_ferr_set;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_full;
    logic              w_avail;
    logic              w_pop;
    logic              w_push;
    logic              w_ovr_set;
    logic              w_stat_wr;
    logic              r_overrun;
    logic              r_frameerr;
    logic [7:0]        r_dout;
    logic [7:0]        w_rdata;

    assign w_rx     = r_sync[1];
    assign w_tick   = (r_tick_cnt == 9'd0);
    assign w_decide = w_tick && (r_tcnt == c_DECIDE_TCNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rxin};
            r_rx_prev <= w_rx;
        end
    end

    // Reload value 2*PERIOD+1 gives one tick every 2*(PERIOD+1) clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= 9'd0;
        end else if (w_restart || w_tick) begin
            r_tick_cnt <= {r_period, 1'b1};
        end else begin
            r_tick_cnt <= r_tick_cnt - 9'd1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_maj;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_maj <= 2'b11;
        end else if (w_tick && (r_tcnt == 4'd6)) begin
            r_maj[0] <= w_rx;
        end else if (w_tick && (r_tcnt == 4'd7)) begin
            r_maj[1] <= w_rx;
        end
    end
    assign w_sample = (r_maj[0] & r_maj[1]) | (r_maj[0] & w_rx) | (r_maj[1] & w_rx);
`else
    assign w_sample = w_rx;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_shift     = 1'b0;
        w_push_req  = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rx_prev && !w_rx) begin
                    w_state_nxt = S_START;
                    w_restart   = 1'b1;
                end
            end
            S_START: begin
                if (w_decide) begin
                    w_state_nxt = w_sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_decide) begin
                    w_shift = 1'b1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_decide) begin
                    if (w_sample) begin
                        w_push_req  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = S_WAITHI;
                    end
                end
            end
            S_WAITHI: begin
                if (w_rx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bit-phase tick count wraps every 16 ticks, aligned to the start edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt   <= 4'd0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
        end else begin
            if (w_restart) begin
                r_tcnt   <= 4'd0;
                r_bitcnt <= 3'd0;
            end else begin
                if (w_tick) begin
                    r_tcnt <= r_tcnt + 4'd1;
                end
                if (w_shift) begin
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
            end
            if (w_shift) begin
                r_shift <= {w_sample, r_shift[7:1]};
            end
        end
    end

    assign w_full    = (r_count == c_DEPTH);
    assign w_avail   = (r_count != '0);
    assign w_pop     = rden && (addr == c_ADDR_RXDATA) && w_avail;
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovr_set = w_push_req && w_full && !w_pop;
    assign w_stat_wr = wren && (addr == c_ADDR_STATUS);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A flag set in the same cycle as a clearing write takes priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun  <= 1'b0;
            r_frameerr <= 1'b0;
            r_period   <= c_PERIOD_RST;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_stat_wr) begin
                r_overrun <= 1'b0;
            end
            if (w_ferr_set) begin
                r_frameerr <= 1'b1;
            end else if (w_stat_wr) begin
                r_frameerr <= 1'b0;
            end
            if (wren && (addr == c_ADDR_PERIOD)) begin
                r_period <= din;
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (addr)
            c_ADDR_PERIOD: w_rdata = r_period;
            c_ADDR_RXDATA: if (w_avail) w_rdata = r_mem[r_rd_ptr];
            c_ADDR_STATUS: w_rdata = {4'b0000, r_frameerr, r_overrun, w_full, w_avail};
            default:       w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= 8'h00;
        end else if (rden) begin
            r_dout <= w_rdata;
        end
    end

    assign dout  = r_dout;
    assign rxirq = w_avail;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx: register-map vector table,
//            directed frame sequences and randomized bytes vs. a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       wren    = 1'b0;
    logic       rden    = 1'b0;
    logic [2:0] addr    = 3'd0;
    logic [7:0] din     = 8'h00;
    logic       rxin    = 1'b1;
    logic [7:0] dout;
    logic       rxirq;

    int errors   = 0;
    int checks   = 0;
    int bit_clks = 416;

    typedef struct {
        logic       wr;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [15];

    uart_rx #(.FIFO_DEPTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wren    (wren),
        .rden    (rden),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .rxin    (rxin),
        .rxirq   (rxirq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wren = 1'b1;
        addr = a;
        din  = d;
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        rden = 1'b1;
        addr = a;
        @(negedge clk);
        rden = 1'b0;
        d    = dout;
    endtask

    task automatic set_period(input logic [7:0] p);
        reg_write(3'd0, p);
        bit_clks = 32 * (int'(p) + 1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxin = f[i];
            repeat (bit_clks) @(negedge clk);
        end
        rxin = 1'b1;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] exp_b;
        logic [7:0] sent [9];
        logic [7:0] q [$];
        logic       ovr;
        int         n;

        vecs[0]  = '{1'b0, 3'd0, 8'h00, 8'h0C};
        vecs[1]  = '{1'b0, 3'd3, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 3'd2, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 3'd0, 8'hA7, 8'h00};
        vecs[4]  = '{1'b0, 3'd0, 8'h00, 8'hA7};
        vecs[5]  = '{1'b1, 3'd1, 8'hFF, 8'h00};
        vecs[6]  = '{1'b0, 3'd1, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 3'd5, 8'h55, 8'h00};
        vecs[8]  = '{1'b0, 3'd5, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 3'd7, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 3'd3, 8'hFF, 8'h00};
        vecs[11] = '{1'b0, 3'd3, 8'h00, 8'h00};
        vecs[12] = '{1'b0, 3'd0, 8'h00, 8'hA7};
        vecs[13] = '{1'b1, 3'd0, 8'h0C, 8'h00};
        vecs[14] = '{1'b0, 3'd0, 8'h00, 8'h0C};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_dout", dout, 8'h00);
        check("reset_rxirq", {7'd0, rxirq}, 8'h00);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Register map table
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                reg_write(vecs[i].a, vecs[i].d);
            end else begin
                reg_read(vecs[i].a, rd);
                check($sformatf("regmap[%0d]", i), rd, vecs[i].exp);
            end
        end
        repeat (4) @(negedge clk);
        check("dout_hold", dout, 8'h0C);

        // Single frame at 416 clocks/bit
        send_frame(8'h55, 1'b1);
        check("rxirq_after_55", {7'd0, rxirq}, 8'h01);
        reg_read(3'd2, rd);
        check("rxdata_55", rd, 8'h55);
        check("rxirq_after_pop", {7'd0, rxirq}, 8'h00);

        // 100-clock low glitch is a false start
        rxin = 1'b0;
        repeat (100) @(negedge clk);
        rxin = 1'b1;
        repeat (bit_clks) @(negedge clk);
        check("glitch_rxirq", {7'd0, rxirq}, 8'h00);
        reg_read(3'd3, rd);
        check("glitch_status", rd, 8'h00);
        send_frame(8'hC3, 1'b1);
        reg_read(3'd2, rd);
        check("after_glitch_C3", rd, 8'hC3);

        // Back-to-back frames
        send_frame(8'h1A, 1'b1);
        send_frame(8'hE2, 1'b1);
        send_frame(8'h39, 1'b1);
        reg_read(3'd2, rd);
        check("b2b_0", rd, 8'h1A);
        reg_read(3'd2, rd);
        check("b2b_1", rd, 8'hE2);
        reg_read(3'd2, rd);
        check("b2b_2", rd, 8'h39);
        reg_read(3'd3, rd);
        check("b2b_status", rd, 8'h00);

        // Faster bit rate for the remaining sequences
        set_period(8'h03);
        reg_read(3'd0, rd);
        check("period_03", rd, 8'h03);

        // Overflow: nine bytes, no reads
        for (int i = 0; i < 9; i++) begin
            sent[i] = 8'($urandom);
            send_frame(sent[i], 1'b1);
        end
        reg_read(3'd3, rd);
        check("ovf_status_full", rd, 8'h07);
        check("ovf_rxirq", {7'd0, rxirq}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            reg_read(3'd2, rd);
            check($sformatf("ovf_data[%0d]", i), rd, sent[i]);
        end
        reg_read(3'd3, rd);
        check("ovf_status_drained", rd, 8'h04);
        reg_read(3'd2, rd);
        check("empty_read", rd, 8'h00);
        reg_write(3'd3, 8'($urandom));
        reg_read(3'd3, rd);
        check("ovf_cleared", rd, 8'h00);

        // Framing error then a good byte
        send_frame(8'h81, 1'b0);
        repeat (bit_clks) @(negedge clk);
        reg_read(3'd3, rd);
        check("ferr_status", rd, 8'h08);
        check("ferr_rxirq", {7'd0, rxirq}, 8'h00);
        send_frame(8'hA5, 1'b1);
        reg_read(3'd3, rd);
        check("ferr_then_A5_status", rd, 8'h09);
        reg_read(3'd2, rd);
        check("ferr_then_A5", rd, 8'hA5);
        reg_write(3'd3, 8'h00);
        reg_read(3'd3, rd);
        check("ferr_cleared", rd, 8'h00);

        // Reset asserted in the middle of the data bits
        send_frame(8'h7E, 1'b1);
        reg_read(3'd3, rd);
        check("pre_reset_status", rd, 8'h01);
        rxin = 1'b0;
        repeat (bit_clks) @(negedge clk);
        rxin = 1'b1;
        repeat (bit_clks) @(negedge clk);
        rxin = 1'b0;
        repeat (bit_clks / 2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midframe_reset_dout", dout, 8'h00);
        check("midframe_reset_rxirq", {7'd0, rxirq}, 8'h00);
        rxin = 1'b1;
        repeat (10) @(negedge clk);
        reset_n  = 1'b1;
        bit_clks = 416;
        reg_read(3'd0, rd);
        check("post_reset_period", rd, 8'h0C);
        reg_read(3'd3, rd);
        check("post_reset_status", rd, 8'h00);
        send_frame(8'h3C, 1'b1);
        reg_read(3'd2, rd);
        check("post_reset_3C", rd, 8'h3C);

        // Randomized bursts against a queue model
        for (int r = 0; r < 3; r++) begin
            exp_b = 8'($urandom_range(1, 2));
            set_period(exp_b);
            reg_read(3'd0, rd);
            check($sformatf("rnd%0d_period", r), rd, exp_b);
            n   = $urandom_range(1, 9);
            ovr = 1'b0;
            for (int i = 0; i < n; i++) begin
                exp_b = 8'($urandom);
                send_frame(exp_b, 1'b1);
                if (q.size() < 8) q.push_back(exp_b);
                else ovr = 1'b1;
            end
            reg_read(3'd3, rd);
            check($sformatf("rnd%0d_status", r), rd,
                  {5'd0, ovr, q.size() == 8, q.size() != 0});
            while (q.size() > 0) begin
                exp_b = q.pop_front();
                reg_read(3'd2, rd);
                check($sformatf("rnd%0d_data", r), rd, exp_b);
            end
            reg_read(3'd3, rd);
            check($sformatf("rnd%0d_status_empty", r), rd, {5'd0, ovr, 2'b00});
            reg_write(3'd3, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
